// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM with IR field decode; optional FETCH_TIMEOUT_EN fetch watchdog
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    output logic [5:0]  opcode,
    output logic        RA,
    output logic [1:0]  RA_stack,
    output logic [8:0]  Immediate,
    output logic        instr_valid,
    output logic [9:0]  pc,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

    localparam logic [5:0] OP_HLT = 6'b111111;

    state_t      state, state_nx;
    logic [15:0] ir;
    logic [9:0]  pc_q, pc_nx;
    logic        ir_load;
    logic        timeout;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err_q;

    // Count ack-less FETCH cycles; held at zero outside FETCH so every fetch starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= 4'd0;
        else if (state != S_FETCH || imem_ack)
            wait_cnt <= 4'd0;
        else
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Sticky error flag once a fetch has gone unanswered for 16 cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end

    assign timeout   = (state == S_FETCH) && !imem_ack && (wait_cnt == 4'hF);
    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State, program counter and instruction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc_q  <= 10'd0;
            ir    <= 16'd0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            if (ir_load)
                ir <= imem_rdata;
        end
    end

    // Next-state logic; HLT is checked before branch so it wins
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        ir_load  = 1'b0;
        case (state)
            S_IDLE:  state_nx = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = S_ISSUE;
                end else if (timeout) begin
                    state_nx = S_HALT;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (ir[15:10] == OP_HLT) begin
                        state_nx = S_HALT;
                    end else if (branch_taken) begin
                        pc_nx    = branch_target;
                        state_nx = S_FETCH;
                    end else begin
                        pc_nx    = pc_q + 10'd1;
                        state_nx = S_FETCH;
                    end
                end
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALT);
    assign pc          = pc_q;
    assign opcode      = ir[15:10];
    assign RA          = ir[9];
    assign RA_stack    = ir[9:8];
    assign Immediate   = ir[8:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [5:0]  opcode;
    logic        RA;
    logic [1:0]  RA_stack;
    logic [8:0]  Immediate;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        halted;
    logic        fetch_err;

    typedef struct {
        logic [15:0] word;
        logic [9:0]  addr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [5:0]  last_op;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .opcode(opcode), .RA(RA), .RA_stack(RA_stack), .Immediate(Immediate),
        .instr_valid(instr_valid), .pc(pc), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, optionally delay the ack, then
    // return the word and check the decoded ISSUE cycle against the scoreboard.
    task automatic serve(input logic [15:0] word, input int wait_n, input logic [9:0] exp_addr);
        exp_t e;
        int   n = 0;
        while (!imem_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
        for (int i = 0; i < wait_n; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            check("wait_ir_hold", {26'd0, opcode}, {26'd0, last_op});
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back('{word: word, addr: exp_addr});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        e = sb.pop_front();
        check("issue_valid", {31'd0, instr_valid}, 32'd1);
        check("issue_req", {31'd0, imem_req}, 32'd0);
        check("opcode", {26'd0, opcode}, {26'd0, e.word[15:10]});
        check("RA", {31'd0, RA}, {31'd0, e.word[9]});
        check("RA_stack", {30'd0, RA_stack}, {30'd0, e.word[9:8]});
        check("Immediate", {23'd0, Immediate}, {23'd0, e.word[8:0]});
        check("issue_pc", {22'd0, pc}, {22'd0, e.addr});
        last_op = e.word[15:10];
    endtask

    task automatic go(input logic st, input logic br, input logic [9:0] tgt);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        stall         = 1'b0;
        branch_taken  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, {22'd0, imem_addr}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        check({tag, "_pc"}, {22'd0, pc}, 32'd0);
        check({tag, "_ir"}, {16'd0, opcode, RA_stack, Immediate[7:0]}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 10'h0; last_op = 6'd0;

        // Reset state, then release on a negedge
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("req_cycle1", {31'd0, imem_req}, 32'd1);

        // Zero-wait fetch of 5A03 at address 0
        serve(16'h5A03, 0, 10'h000);
        check("dec_opcode", {26'd0, opcode}, 32'h16);
        check("dec_RA", {31'd0, RA}, 32'd1);
        check("dec_stack", {30'd0, RA_stack}, 32'd2);
        check("dec_imm", {23'd0, Immediate}, 32'h003);
        go(1'b0, 1'b0, 10'h0);

        // Five-cycle memory wait at address 1, then stalled branch
        serve(16'h1234, 5, 10'h001);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; branch_taken = 1'b1; branch_target = 10'h2A0;
            @(negedge clk);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", {22'd0, pc}, 32'h001);
            check("stall_ir", {26'd0, opcode}, 32'h04);
        end
        go(1'b0, 1'b1, 10'h2A0);
        check("branch_addr", {22'd0, imem_addr}, 32'h2A0);

        // Branch to 1023, then sequential wrap to 0, then HLT beats branch
        serve(16'h0ABC, 0, 10'h2A0);
        go(1'b0, 1'b1, 10'h3FF);
        serve(16'h8155, 0, 10'h3FF);
        go(1'b0, 1'b0, 10'h0);
        check("wrap_addr", {22'd0, imem_addr}, 32'h000);
        serve(16'hFC00, 0, 10'h000);
        go(1'b0, 1'b1, 10'h155);
        for (int i = 0; i < 4; i++) begin
            check("hlt_halted", {31'd0, halted}, 32'd1);
            check("hlt_req", {31'd0, imem_req}, 32'd0);
            check("hlt_valid", {31'd0, instr_valid}, 32'd0);
            check("hlt_pc", {22'd0, pc}, 32'h000);
            @(negedge clk);
        end

        // Reset pulsed mid-fetch with a late ack
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b0;
        #1 check_zero("async");
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_req", {31'd0, imem_req}, 32'd1);
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_ir", {16'd0, opcode, RA_stack, Immediate[7:0]}, 32'd0);
        last_op = 6'd0;
        serve(16'h0C01, 0, 10'h000);
        go(1'b0, 1'b0, 10'h0);

        // Fetch with no ack at all
        for (int i = 0; i < 16; i++) begin
            check("to_req", {31'd0, imem_req}, 32'd1);
            check("to_addr", {22'd0, imem_addr}, 32'h001);
            @(negedge clk);
        end
`ifdef FETCH_TIMEOUT_EN
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_req_drop", {31'd0, imem_req}, 32'd0);
`else
        repeat (4) @(negedge clk);
        check("nto_req", {31'd0, imem_req}, 32'd1);
        check("nto_err", {31'd0, fetch_err}, 32'd0);
        check("nto_halted", {31'd0, halted}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: imem_req  out  1  instruction-memory read request.
REQ-004 SHALL have ports: imem_addr  out  10  word address of the requested instruction.
REQ-005 SHALL have ports: imem_ack  in  1  memory read-data-valid strobe.
REQ-006 SHALL have ports: imem_rdata  in  16  instruction word, valid when imem_ack=1.
REQ-007 SHALL have ports: stall  in  1  hold the current instruction; do not advance.
REQ-008 SHALL have ports: branch_taken  in  1  redirect request from branch resolution, sampled only in ISSUE.
REQ-009 SHALL have ports: branch_target  in  10  redirect address.
REQ-010 SHALL have ports: opcode  out  6  IR[15:10].
REQ-011 SHALL have ports: RA  out  1  IR[9].
REQ-012 SHALL have ports: RA_stack  out  2  IR[9:8].
REQ-013 SHALL have ports: Immediate  out  9  IR[8:0].
REQ-014 SHALL have ports: instr_valid  out  1  fields hold a decodable instruction.
REQ-015 SHALL have ports: pc  out  10  address of the instruction in IR.
REQ-016 SHALL have ports: halted  out  1  core stopped on a HLT instruction.
REQ-017 SHALL have ports: fetch_err  out  1  fetch timeout (FETCH_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-018 SHALL implement a four-state FSM: IDLE, FETCH, ISSUE, HALT.
REQ-019 IDLE SHALL go to FETCH on the first clock after reset deasserts, with no outputs active.
REQ-020 FETCH SHALL drive imem_req=1 and imem_addr=pc each cycle until imem_ack=1, holding imem_addr stable.
REQ-021 FETCH with imem_ack=1 SHALL load imem_rdata into the 16-bit IR and go to ISSUE; imem_req SHALL drop in the following cycle.
REQ-022 An imem_ack arriving outside FETCH SHALL be ignored.
REQ-023 ISSUE SHALL drive instr_valid=1; opcode, RA, RA_stack and Immediate SHALL be combinational slices of IR and stable during ISSUE.
REQ-024 In ISSUE with stall=1, the FSM SHALL stay in ISSUE with IR and pc unchanged; branch_taken SHALL be ignored.
REQ-025 In ISSUE with stall=0 and opcode=6'b111111 (HLT), the FSM SHALL go to HALT; pc SHALL not change.
REQ-026 In ISSUE with stall=0, a non-HLT opcode and branch_taken=1, pc SHALL load branch_target and the FSM SHALL go to FETCH.
REQ-027 In ISSUE with stall=0, a non-HLT opcode and branch_taken=0, pc SHALL become pc+1 modulo 1024 (1023 wraps to 0), and the FSM SHALL go to FETCH.
REQ-028 HLT SHALL take precedence over branch_taken.
REQ-029 HALT SHALL drive halted=1, instr_valid=0 and imem_req=0, and SHALL be left only by reset.
REQ-030 Fetch-to-issue latency SHALL be one cycle after imem_ack; the minimum instruction period SHALL be 2 cycles with a zero-wait memory.
REQ-031 instr_valid SHALL be 0 in all states except ISSUE.

Reset
REQ-032 rst=0 SHALL immediately, without waiting for a clock edge, force IDLE, pc=0, IR=0, imem_req=0, imem_addr=0, instr_valid=0, halted=0 and fetch_err=0.
REQ-033 Reset asserted mid-fetch SHALL abandon the request; an imem_ack arriving after reset SHALL be ignored until the next FETCH.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; at the 16th such cycle the FSM SHALL go to HALT, set fetch_err=1 sticky, and drop imem_req.
REQ-035 Macro FETCH_TIMEOUT_EN undefined: FETCH SHALL wait indefinitely, no counter SHALL exist, and fetch_err SHALL be constant 0.

Verification
REQ-036 Reset release with zero-wait memory returning 16'h5A03 at address 0 -> imem_req at cycle 1, ISSUE with opcode=6'b010110, RA=1, RA_stack=2'b10, Immediate=9'h003, pc=0, then fetch of address 1.
REQ-037 Memory ack delayed by 5 cycles -> imem_addr stable and imem_req=1 for 6 cycles, instr_valid=0 throughout, IR loaded only on ack.
REQ-038 ISSUE with stall=1 for 3 cycles and branch_taken=1, branch_target=10'h2A0 -> IR and pc unchanged; after stall drops with branch_taken=1, the next imem_addr is 10'h2A0.
REQ-039 pc=1023 with non-branch instruction -> next imem_addr=0; HLT word 16'hFC00 -> halted=1 and no further imem_req, even with branch_taken=1.
REQ-040 Reset pulsed while imem_req=1, with a late ack afterward -> all outputs zero immediately, late ack ignored, refetch from address 0.
REQ-041 With FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, halted=1, imem_req=0; without the macro, the same stimulus -> imem_req held and fetch_err=0.
